// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM state type and default parameters for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD_RST,
        SEQ,
        RUN
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: soft-reset request in, sequenced channel resets and done flag out.
interface rst_seq_if import rst_seq_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH
);

    logic              sw_rst_req;
    logic [NUM_CH-1:0] rst_out;
    logic              rst_done;

    modport master (
        output sw_rst_req,
        input  rst_out,
        input  rst_done
    );

    modport slave (
        input  sw_rst_req,
        output rst_out,
        output rst_done
    );

endinterface

// File: rtl/rst_seq_sync.sv
// rst_sync: asynchronous-assert, synchronous-release reset synchronizer chain.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync_out
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chain <= '1;
        else
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
    end

    assign rst_sync_out = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: releases NUM_CH resets in ascending order, HOLD_CYCLES apart, after
// the synchronized hard reset or a soft-reset request.
module rst_seq import rst_seq_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input logic      clk,
    input logic      rst,
    rst_seq_if.slave bus
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(NUM_CH + 1);

    logic              w_sync;
    logic              w_step;
    state_t            r_state, w_state;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [IW-1:0]     r_idx, w_idx;
    logic [NUM_CH-1:0] r_out, w_out;
    logic              r_done, w_done;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk          (clk),
        .rst          (rst),
        .rst_sync_out (w_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HOLD_RST;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= '1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_out   <= w_out;
            r_done  <= w_done;
        end
    end

    // The first edge seen with the synchronizer released counts as sequence edge 1,
    // so the HOLD_RST exit behaves as a SEQ step from a zero counter.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_out   = r_out;
        w_done  = r_done;
        w_step  = (r_state == SEQ) || (r_state == HOLD_RST && !w_sync);
        if (bus.sw_rst_req && !w_sync) begin
            w_state = SEQ;
            w_cnt   = '0;
            w_idx   = '0;
            w_out   = '1;
            w_done  = 1'b0;
        end else if (w_step) begin
            w_state = SEQ;
            if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                w_cnt = '0;
                w_idx = r_idx + IW'(1);
                w_out = r_out & ~(NUM_CH'(1) << r_idx);
                if (r_idx == IW'(NUM_CH - 1)) begin
                    w_state = RUN;
                    w_done  = 1'b1;
                end
            end else begin
                w_cnt = r_cnt + CW'(1);
            end
        end
    end

    assign bus.rst_out  = r_out;
    assign bus.rst_done = r_done;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2; number of synchronizer flops, legal range >= 2.
REQ-002 SHALL have parameter NUM_CH, default 4; number of sequenced reset outputs, legal range >= 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16; cycles between successive channel releases, legal range >= 1.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sw_rst_req  input  1  synchronous soft-reset request, sampled on rising clk.
REQ-007 SHALL have port rst_out  output  NUM_CH  per-channel reset, active-high; bit i belongs to channel i.
REQ-008 SHALL have port rst_done  output  1  high only when every rst_out bit is low.

Function
REQ-009 SHALL assert all rst_out bits and clear rst_done asynchronously, same instant rst rises.
REQ-010 SHALL release the internal synchronized reset on the SYNC_STAGES-th rising clk edge after rst falls (edges counted from the first edge with rst low).
REQ-011 SHALL use an FSM with states HOLD_RST (sync reset active), SEQ (releasing channels), RUN (all released).
REQ-012 SHALL leave HOLD_RST for SEQ on the edge the synchronized reset releases; the hold counter and channel index SHALL be zero on that edge.
REQ-013 SHALL, in SEQ, deassert rst_out[i] on edge S+(i+1)*HOLD_CYCLES, where S is the sync-release edge; release order SHALL be channel 0 first, ascending.
REQ-014 SHALL leave channels released; a released bit SHALL NOT reassert except by rst or sw_rst_req.
REQ-015 SHALL enter RUN and raise rst_done on the same edge rst_out[NUM_CH-1] deasserts.
REQ-016 SHALL, on any edge with sw_rst_req high, set all rst_out bits and clear rst_done on that edge, zero the counter and index, and enter SEQ, in any state.
REQ-017 SHALL, after sw_rst_req, release channel i on edge T+(i+1)*HOLD_CYCLES, where T is the last edge sw_rst_req was sampled high; no synchronizer delay applies.
REQ-018 SHALL keep all outputs asserted while sw_rst_req is held high continuously.
REQ-019 SHALL give rst priority over sw_rst_req; rst mid-sequence restarts from HOLD_RST.
REQ-020 SHALL size the hold counter $clog2(HOLD_CYCLES+1) bits and the channel index $clog2(NUM_CH+1) bits, with no wrap-around inside SEQ.
REQ-021 SHALL drive rst_out and rst_done directly from flops; no combinational path from sw_rst_req to outputs.

Reset
REQ-022 SHALL, during rst high, hold rst_out = all ones, rst_done = 0, FSM = HOLD_RST, counter = 0, index = 0, synchronizer chain = all ones.
REQ-023 SHALL clock every flop in the block on posedge clk, with an asynchronous clear/preset on rst. The synchronizer output SHALL be the only reset used to leave HOLD_RST.

Structure
REQ-024 SHALL place the FSM state enum (HOLD_RST, SEQ, RUN) and the default parameter constants in package rst_seq_pkg.
REQ-025 SHALL instantiate sub-module rst_sync (parameter SYNC_STAGES; ports clk, rst, rst_sync_out) for the async-assert/sync-release chain.
REQ-026 SHALL have rst_sync assert its output asynchronously and shift in zeros after rst falls.

Verification (SYNC_STAGES=2, NUM_CH=4, HOLD_CYCLES=16)
REQ-027 SHALL cover power-on: rst high 5 cycles then low -> rst_out=4'b1111 until edge 18; 4'b1110 at 18, 4'b1100 at 34, 4'b1000 at 50, 4'b0000 and rst_done=1 at 66.
REQ-028 SHALL cover async assertion: rst pulsed high mid-cycle in RUN -> rst_out=4'b1111 and rst_done=0 before the next clk edge; the release sequence then repeats as in REQ-027.
REQ-029 SHALL cover soft reset: one-cycle sw_rst_req at edge T in RUN -> rst_out=4'b1111 after T; 4'b1110 at T+16, 4'b0000 and rst_done=1 at T+64.
REQ-030 SHALL cover soft reset mid-sequence: sw_rst_req at edge 40 of power-on sequence -> rst_out=4'b1111 after 40; ch0 releases at 56, ch3 at 104.
REQ-031 SHALL cover held request: sw_rst_req high for 30 edges (last sampled at T) -> rst_out stays 4'b1111 throughout; ch0 releases at T+16.
REQ-032 SHALL cover priority: rst and sw_rst_req both high -> rst behaviour only; sequence restarts from HOLD_RST with the 2-edge synchronizer delay.
